// File: rtl/alu_wb_if.sv
// alu_wb_if: handshake bundle between the ALU, the writeback buffer and the
// downstream consumer.
//   in_*      : ALU operation capture (valid/ready), driven by the ALU side
//   out_*     : byte-beat drain bus (valid/ready), consumed downstream
// Modports:
//   master : environment side (drives in_* payload and out_ready)
//   slave  : writeback buffer side (drives in_ready and out_* payload)
interface alu_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [7:0]  in_result;
  logic [15:0] in_product;
  logic        in_of;
  logic        in_zero;
  logic        in_slt;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_op, in_result, in_product, in_of, in_zero, in_slt,
    output out_ready,
    input  in_ready, out_valid, out_data, out_last, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_result, in_product, in_of, in_zero, in_slt,
    input  out_ready,
    output in_ready, out_valid, out_data, out_last, out_flags
  );
endinterface

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: writeback stage behind the 8-bit ALU. Each accepted legal
// ALU operation is queued in a DEPTH-entry FIFO and drained as byte beats:
// one beat (result) for ordinary ops, two beats (product low, then high)
// for the multiply op 4'b1011. Illegal ops (4'b1100..4'b1111) are accepted
// and dropped, flagging sticky_ill. Sticky overflow tracks pushed OF=1 ops.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (alu_wb_if)     : input capture handshake and output beat bus
//   clr_sticky          : clears sticky_of / sticky_ill (a same-cycle set wins)
//   sticky_of/ill       : sticky status for the controller
//   level               : current FIFO occupancy
//   perf_ops/perf_stall : only with ALU_WB_PERF_EN defined; saturating
//                         counts of popped entries and stalled cycles
module alu_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_wb_if.slave          bus,
  input  logic             clr_sticky,
  output logic             sticky_of,
  output logic             sticky_ill,
  output logic [PTR_W:0]   level
`ifdef ALU_WB_PERF_EN
  ,
  output logic [15:0]      perf_ops,
  output logic [15:0]      perf_stall
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [3:0]     OP_MUL   = 4'b1011;

  typedef enum logic {BEAT_LO = 1'b0, BEAT_HI = 1'b1} beat_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= 4'd11);
  endfunction

  logic [3:0]       mem_op      [DEPTH];
  logic [7:0]       mem_result  [DEPTH];
  logic [15:0]      mem_product [DEPTH];
  logic [2:0]       mem_flags   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  beat_e            beat_r;
  beat_e            beat_nxt_s;
  logic             sticky_of_r;
  logic             sticky_ill_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             legal_s;
  logic             push_s;
  logic             pop_s;
  logic             out_valid_s;
  logic             beat_acc_s;
  logic             head_mul_s;
  logic [7:0]       out_data_s;
  logic             out_last_s;
  logic [2:0]       out_flags_s;

  // in_ready depends only on registered count, so a pop never frees a slot
  // in the same cycle.
  assign in_ready_s  = (count_r != FULL_CNT);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign legal_s     = op_is_legal(bus.in_op);
  assign push_s      = accept_s && legal_s;
  assign out_valid_s = (count_r != {(PTR_W+1){1'b0}});
  assign beat_acc_s  = out_valid_s && bus.out_ready;
  assign head_mul_s  = (mem_op[rd_ptr_r] == OP_MUL);

  // Beat selection, pop decision and next beat state from the head entry.
  always_comb begin
    beat_nxt_s  = beat_r;
    out_data_s  = 8'd0;
    out_last_s  = 1'b0;
    out_flags_s = 3'd0;
    pop_s       = 1'b0;
    if (out_valid_s) begin
      out_flags_s = mem_flags[rd_ptr_r];
      case (beat_r)
        BEAT_LO: begin
          if (head_mul_s) begin
            out_data_s = mem_product[rd_ptr_r][7:0];
            out_last_s = 1'b0;
            if (beat_acc_s) begin
              beat_nxt_s = BEAT_HI;
            end else begin
              beat_nxt_s = BEAT_LO;
            end
          end else begin
            out_data_s = mem_result[rd_ptr_r];
            out_last_s = 1'b1;
            pop_s      = beat_acc_s;
          end
        end
        BEAT_HI: begin
          out_data_s = mem_product[rd_ptr_r][15:8];
          out_last_s = 1'b1;
          pop_s      = beat_acc_s;
          if (beat_acc_s) begin
            beat_nxt_s = BEAT_LO;
          end else begin
            beat_nxt_s = BEAT_HI;
          end
        end
        default: begin
          beat_nxt_s = BEAT_LO;
        end
      endcase
    end else begin
      beat_nxt_s = BEAT_LO;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_op[wr_ptr_r]      <= bus.in_op;
      mem_result[wr_ptr_r]  <= bus.in_result;
      mem_product[wr_ptr_r] <= bus.in_product;
      mem_flags[wr_ptr_r]   <= {bus.in_of, bus.in_zero, bus.in_slt};
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
      end else if (pop_s && !push_s) begin
        count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Beat state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_r <= BEAT_LO;
    end else begin
      beat_r <= beat_nxt_s;
    end
  end

  // Sticky status; a set in the same cycle as clr_sticky takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_of_r  <= 1'b0;
      sticky_ill_r <= 1'b0;
    end else begin
      if (push_s && bus.in_of) begin
        sticky_of_r <= 1'b1;
      end else if (clr_sticky) begin
        sticky_of_r <= 1'b0;
      end
      if (accept_s && !legal_s) begin
        sticky_ill_r <= 1'b1;
      end else if (clr_sticky) begin
        sticky_ill_r <= 1'b0;
      end
    end
  end

`ifdef ALU_WB_PERF_EN
  logic [15:0] perf_ops_r;
  logic [15:0] perf_stall_r;

  // Saturating performance counters, cleared alongside the sticky bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_r   <= 16'd0;
      perf_stall_r <= 16'd0;
    end else if (clr_sticky) begin
      perf_ops_r   <= 16'd0;
      perf_stall_r <= 16'd0;
    end else begin
      if (pop_s && (perf_ops_r != 16'hFFFF)) begin
        perf_ops_r <= perf_ops_r + 16'd1;
      end
      if (out_valid_s && !bus.out_ready && (perf_stall_r != 16'hFFFF)) begin
        perf_stall_r <= perf_stall_r + 16'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_r;
  assign perf_stall = perf_stall_r;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.out_last  = out_last_s;
  assign bus.out_flags = out_flags_s;
  assign sticky_of     = sticky_of_r;
  assign sticky_ill    = sticky_ill_r;
  assign level         = count_r;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb_alu_wb_buffer: directed scenarios plus a randomized run against a
// beat-queue reference model of the writeback buffer.
module tb_alu_wb_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_sticky;
  logic             sticky_of;
  logic             sticky_ill;
  logic [PTR_W:0]   level;
`ifdef ALU_WB_PERF_EN
  logic [15:0]      perf_ops;
  logic [15:0]      perf_stall;
`endif

  alu_wb_if bus();

  alu_wb_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_of  (sticky_of),
    .sticky_ill (sticky_ill),
    .level      (level)
`ifdef ALU_WB_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending output beats plus entry count.
  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [2:0] flags;
  } beat_t;

  beat_t bq[$];
  int    m_level;
  bit    m_sof;
  bit    m_sill;

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] res,
                       input logic [15:0] prod, input logic [2:0] fl,
                       input logic ordy, input logic clr);
    bus.in_valid   = v;
    bus.in_op      = op;
    bus.in_result  = res;
    bus.in_product = prod;
    bus.in_of      = fl[2];
    bus.in_zero    = fl[1];
    bus.in_slt     = fl[0];
    bus.out_ready  = ordy;
    clr_sticky     = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    bq.delete();
    m_level = 0;
    m_sof   = 1'b0;
    m_sill  = 1'b0;
  endtask

  // Predict the effect of the next clock edge from the inputs now driven.
  task automatic model_step();
    bit    acc;
    bit    legal;
    beat_t b;
    acc   = bus.in_valid && (m_level != DEPTH);
    legal = (bus.in_op <= 4'd11);
    if (bq.size() != 0 && bus.out_ready) begin
      b = bq.pop_front();
      if (b.last) m_level--;
    end
    if (acc && legal) begin
      if (bus.in_op == 4'd11) begin
        bq.push_back('{bus.in_product[7:0], 1'b0, {bus.in_of, bus.in_zero, bus.in_slt}});
        bq.push_back('{bus.in_product[15:8], 1'b1, {bus.in_of, bus.in_zero, bus.in_slt}});
      end else begin
        bq.push_back('{bus.in_result, 1'b1, {bus.in_of, bus.in_zero, bus.in_slt}});
      end
      m_level++;
    end
    if (acc && legal && bus.in_of) m_sof = 1'b1;
    else if (clr_sticky) m_sof = 1'b0;
    if (acc && !legal) m_sill = 1'b1;
    else if (clr_sticky) m_sill = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
    total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h exp 00", bus.out_data); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b exp 0", bus.out_last); end
    total++; if (bus.out_flags !== 3'b000) begin bad++; $display("FAIL reset_out_flags: got %b exp 000", bus.out_flags); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d exp 0", level); end
    total++; if ({sticky_of, sticky_ill} !== 2'b00) begin bad++; $display("FAIL reset_sticky: got %b exp 00", {sticky_of, sticky_ill}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 4'b1001, 8'h3C, 16'hBEEF, 3'b000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b0);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b exp 1", bus.out_valid); end
    total++; if (bus.out_data !== 8'h3C) begin bad++; $display("FAIL single_data: got %h exp 3c", bus.out_data); end
    total++; if (bus.out_last !== 1'b1) begin bad++; $display("FAIL single_last: got %b exp 1", bus.out_last); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level1: got %0d exp 1", level); end
    tick();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL single_level0: got %0d exp 0", level); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_mul();
    drive(1'b1, 4'b1011, 8'h11, 16'hA5F0, 3'b010, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b0);
    total++; if (bus.out_data !== 8'hF0) begin bad++; $display("FAIL mul_lo_data: got %h exp f0", bus.out_data); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL mul_lo_last: got %b exp 0", bus.out_last); end
    total++; if (bus.out_flags !== 3'b010) begin bad++; $display("FAIL mul_lo_flags: got %b exp 010", bus.out_flags); end
    tick();
    total++; if (bus.out_data !== 8'hA5) begin bad++; $display("FAIL mul_hi_data: got %h exp a5", bus.out_data); end
    total++; if (bus.out_last !== 1'b1) begin bad++; $display("FAIL mul_hi_last: got %b exp 1", bus.out_last); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL mul_hi_level: got %0d exp 1", level); end
    tick();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mul_popped: got %0d exp 0", level); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 4'(i), 8'(8'h10 + i), 16'd0, 3'd0, 1'b0, 1'b0);
      tick();
    end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level: got %0d exp 4", level); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %b exp 0", bus.in_ready); end
    drive(1'b1, 4'd5, 8'h55, 16'd0, 3'd0, 1'b1, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_no_passthru: got %b exp 0", bus.in_ready); end
    tick();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b0, 1'b0);
    total++; if (level !== 3'd3) begin bad++; $display("FAIL full_after_pop: got %0d exp 3", level); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back: got %b exp 1", bus.in_ready); end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      total++; if (bus.out_data !== 8'(8'h10 + i)) begin bad++; $display("FAIL full_drain_%0d: got %h exp %h", i, bus.out_data, 8'(8'h10 + i)); end
      tick();
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL full_empty: got %0d exp 0", level); end
  endtask

  task automatic test_sticky();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'b1010, 8'h01, 16'd0, 3'b100, 1'b1, 1'b1);
    tick();
    total++; if (sticky_of !== 1'b1) begin bad++; $display("FAIL sticky_set_wins: got %b exp 1", sticky_of); end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b1);
    tick();
    total++; if (sticky_of !== 1'b0) begin bad++; $display("FAIL sticky_clear: got %b exp 0", sticky_of); end
    drive(1'b1, 4'b1110, 8'hEE, 16'd0, 3'b100, 1'b1, 1'b0);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready: got %b exp 1", bus.in_ready); end
    tick();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b0);
    total++; if (level !== 3'd0) begin bad++; $display("FAIL illegal_level: got %0d exp 0", level); end
    total++; if (sticky_ill !== 1'b1) begin bad++; $display("FAIL illegal_sticky: got %b exp 1", sticky_ill); end
    total++; if (sticky_of !== 1'b0) begin bad++; $display("FAIL illegal_no_of: got %b exp 0", sticky_of); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL illegal_valid: got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b1011, 8'h00, 16'h1234, 3'b001, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b0);
    total++; if (bus.out_data !== 8'h34) begin bad++; $display("FAIL mid_lo_data: got %h exp 34", bus.out_data); end
    tick();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b0, 1'b0);
    total++; if (bus.out_data !== 8'h12) begin bad++; $display("FAIL mid_hi_data: got %h exp 12", bus.out_data); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b exp 0", bus.out_valid); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_rst_level: got %0d exp 0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b0001, 8'h77, 16'hFFFF, 3'b000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b0, 1'b0);
    total++; if (bus.out_data !== 8'h77) begin bad++; $display("FAIL mid_new_data: got %h exp 77", bus.out_data); end
    total++; if (bus.out_last !== 1'b1) begin bad++; $display("FAIL mid_new_last: got %b exp 1", bus.out_last); end
    drive(1'b0, 4'd0, 8'd0, 16'd0, 3'd0, 1'b1, 1'b0);
    tick();
    total++; if (level !== 3'd0) begin bad++; $display("FAIL mid_new_pop: got %0d exp 0", level); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      total++; if (bus.out_valid !== (bq.size() != 0)) begin bad++; $display("FAIL rnd_valid @%0d: got %b exp %b", cyc, bus.out_valid, bq.size() != 0); end
      total++; if (bus.in_ready !== (m_level != DEPTH)) begin bad++; $display("FAIL rnd_ready @%0d: got %b exp %b", cyc, bus.in_ready, m_level != DEPTH); end
      total++; if (level !== 3'(m_level)) begin bad++; $display("FAIL rnd_level @%0d: got %0d exp %0d", cyc, level, m_level); end
      total++; if ({sticky_of, sticky_ill} !== {m_sof, m_sill}) begin bad++; $display("FAIL rnd_sticky @%0d: got %b exp %b", cyc, {sticky_of, sticky_ill}, {m_sof, m_sill}); end
      if (bq.size() != 0) begin
        total++; if ({bus.out_data, bus.out_last, bus.out_flags} !== {bq[0].data, bq[0].last, bq[0].flags})
          begin bad++; $display("FAIL rnd_beat @%0d: got %h/%b/%b exp %h/%b/%b", cyc, bus.out_data, bus.out_last, bus.out_flags, bq[0].data, bq[0].last, bq[0].flags); end
      end else begin
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rnd_idle_data @%0d: got %h exp 00", cyc, bus.out_data); end
      end
      op = ($urandom_range(0, 3) == 0) ? 4'b1011 : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 9) < 7), op, 8'($urandom), 16'($urandom), 3'($urandom),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
      model_step();
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single();
    test_mul();
    test_full();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
